redirect_flush_scheduler: RTL and testbench
===========================================

// Module: redirect_flush_scheduler
// PURPOSE
//  Arbitrates PC-redirect requests from MEM (taken BR, JMP, JSR, TRAP) and ID (decoded unconditional BR).
//  Accepts at most one redirect per window and drives the PC override (pc_sel/pc_target).
//  Sequences the flush: squashes younger pipeline writes, masks forwarding, then resumes normal issue.
//  Sits between the MEM/ID stage control and the IF PC mux / pipeline control-signal gating.
// PARAMETERS
//  FLUSH_DEPTH  3   unstalled cycles squash is held after a MEM redirect; legal 1..7
// PORTS
//  clk                  in   1   pipeline clock
//  rst_n                in   1   asynchronous active-low reset
//  stall                in   1   global pipeline stall; freezes the FSM and counter
//  mem_redirect_req     in   1   MEM stage resolved a redirect this cycle
//  mem_redirect_kind    in   2   00 BR, 01 JMP, 10 JSR, 11 TRAP
//  mem_redirect_pc      in   16  MEM redirect target
//  id_redirect_req      in   1   ID decoded an unconditional BR
//  id_redirect_pc       in   16  ID redirect target
//  pc_sel               out  1   1 = IF loads pc_target this cycle
//  pc_target            out  16  registered target of the last accepted redirect
//  squash               out  1   gate regfile/mem write/read/branch/jsr/trap enables of EX/MEM/WB
//  squash_ifid          out  1   invalidate the IF/ID latch
//  forwarding_mask      out  2   bit1 MEM->EX, bit0 WB->EX forwarding enable
//  busy                 out  1   state != S_IDLE
// BEHAVIOUR
//  Reset (async on rst_n=0): state S_IDLE, cnt 0, pc_target 16'h0000, pc_sel 0, squash 0,
//   squash_ifid 0, forwarding_mask 2'b11, busy 0.
//  States: S_IDLE, S_FLUSH, S_ID_FLUSH, S_POST.
//  Accept (S_IDLE, S_POST or S_ID_FLUSH, stall=0):
//   mem_redirect_req=1 -> latch mem_redirect_pc, cnt <= FLUSH_DEPTH, go to S_FLUSH.
//   Otherwise id_redirect_req=1 (S_IDLE/S_POST only) -> latch id_redirect_pc, go to S_ID_FLUSH.
//   Simultaneous MEM and ID -> MEM wins; the ID request is dropped.
//   MEM during S_ID_FLUSH preempts it (older instruction) and enters S_FLUSH.
//  Requests while stall=1 are not accepted; the requester must hold them.
//  pc_sel = 1 for exactly the first unstalled cycle of S_FLUSH / S_ID_FLUSH (registered, 1-cycle latency).
//  S_FLUSH: squash=1, squash_ifid=1; cnt decrements on each stall=0 cycle.
//   forwarding_mask = 2'b00 when cnt==1, else 2'b11.
//   All redirect requests are ignored (they come from squashed instructions).
//   cnt==1 && stall=0 -> S_POST.
//  S_ID_FLUSH: squash_ifid=1, squash=0; one unstalled cycle, then S_IDLE.
//  S_POST: forwarding_mask=2'b10, no squash; stall=0 -> S_IDLE unless a new request is accepted.
//  stall=1 in any state: state, cnt, pc_target and all outputs hold; pc_sel stays 0 after its first cycle.
//  cnt width is $clog2(FLUSH_DEPTH+1); cnt never wraps below 1 in S_FLUSH.
//  mem_redirect_kind is informational only; all kinds flush identically.
//  rst_n asserted mid-flush aborts immediately to the reset values; no partial squash is retained.
// CONFIGURATION
//  REDIRECT_STATS_EN defined: adds outputs redirect_count[15:0] and squash_cycles[15:0].
//   redirect_count increments on each accepted MEM or ID redirect.
//   squash_cycles increments on each cycle with squash=1 && stall=0.
//   Both counters saturate at 16'hFFFF and clear on reset.
//  REDIRECT_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset with no requests -> forwarding_mask=2'b11, squash=0, busy=0 for 10 cycles.
//  2. MEM req, pc=16'h3000, stall=0 -> pc_sel=1 one cycle, pc_target=16'h3000.
//     Then squash=1 for 3 cycles, mask 11,11,00; S_POST mask 10; back to S_IDLE.
//  3. MEM req then stall=1 for 2 cycles inside S_FLUSH -> squash held 5 cycles total, cnt frozen while stalled.
//  4. MEM req (16'h4000) and ID req (16'h5000) in the same cycle -> pc_target=16'h4000, S_FLUSH.
//     ID request dropped.
//  5. ID req 16'h2222 -> squash_ifid one cycle, squash=0.
//     A MEM req in that cycle (16'h1111) preempts: pc_target=16'h1111, S_FLUSH entered.
//  6. Reset asserted during S_FLUSH cnt=2 -> outputs return to reset values asynchronously.
//     With REDIRECT_STATS_EN: run two redirects -> redirect_count=2, squash_cycles=6.

Source files
------------

// File: rtl/redirect_flush_scheduler_if.sv
// Redirect request / PC override / flush-control bundle between the MEM/ID
// stage control (master) and the redirect flush scheduler (slave).
interface redirect_flush_scheduler_if;
  logic        mem_redirect_req;
  logic [1:0]  mem_redirect_kind;
  logic [15:0] mem_redirect_pc;
  logic        id_redirect_req;
  logic [15:0] id_redirect_pc;
  logic        pc_sel;
  logic [15:0] pc_target;
  logic        squash;
  logic        squash_ifid;
  logic [1:0]  forwarding_mask;
  logic        busy;

  modport master (
    output mem_redirect_req, mem_redirect_kind, mem_redirect_pc,
    output id_redirect_req, id_redirect_pc,
    input  pc_sel, pc_target, squash, squash_ifid, forwarding_mask, busy
  );

  modport slave (
    input  mem_redirect_req, mem_redirect_kind, mem_redirect_pc,
    input  id_redirect_req, id_redirect_pc,
    output pc_sel, pc_target, squash, squash_ifid, forwarding_mask, busy
  );
endinterface

// File: rtl/redirect_flush_scheduler.sv
// Arbitrates MEM/ID PC redirects, drives the PC override and sequences the pipeline flush.
// Optional statistics counters are enabled with `define REDIRECT_STATS_EN.
module redirect_flush_scheduler #(
  parameter int unsigned FLUSH_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  redirect_flush_scheduler_if.slave bus
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0] redirect_count,
  output logic [15:0] squash_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(FLUSH_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ID_FLUSH, S_POST} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      target_n;
  logic             accept;
  logic             pc_sel_n, squash_n, squash_ifid_n, busy_n;
  logic [1:0]       mask_n;
  logic             unused_kind;

  // Redirect kind does not change the flush sequence.
  assign unused_kind = ^bus.mem_redirect_kind;

  // Next state, then the registered outputs are decoded from the next state.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    target_n = bus.pc_target;
    accept   = 1'b0;
    case (state)
      S_IDLE, S_POST, S_ID_FLUSH: begin
        if (bus.mem_redirect_req) begin
          accept   = 1'b1;
          target_n = bus.mem_redirect_pc;
          cnt_n    = CNT_W'(FLUSH_DEPTH);
          state_n  = S_FLUSH;
        end else if (bus.id_redirect_req && (state != S_ID_FLUSH)) begin
          accept   = 1'b1;
          target_n = bus.id_redirect_pc;
          state_n  = S_ID_FLUSH;
        end else begin
          state_n  = S_IDLE;
        end
      end
      S_FLUSH: begin
        // Requests here come from squashed instructions and are ignored.
        if (cnt == CNT_W'(1)) state_n = S_POST;
        else                  cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = S_IDLE;
    endcase

    pc_sel_n      = accept;
    squash_n      = (state_n == S_FLUSH);
    squash_ifid_n = (state_n == S_FLUSH) || (state_n == S_ID_FLUSH);
    busy_n        = (state_n != S_IDLE);
    case (state_n)
      S_FLUSH: mask_n = (cnt_n == CNT_W'(1)) ? 2'b00 : 2'b11;
      S_POST:  mask_n = 2'b10;
      default: mask_n = 2'b11;
    endcase
  end

  // A stall freezes the FSM, the counter and every output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      bus.pc_target       <= 16'h0000;
      bus.pc_sel          <= 1'b0;
      bus.squash          <= 1'b0;
      bus.squash_ifid     <= 1'b0;
      bus.forwarding_mask <= 2'b11;
      bus.busy            <= 1'b0;
    end else if (!stall) begin
      state               <= state_n;
      cnt                 <= cnt_n;
      bus.pc_target       <= target_n;
      bus.pc_sel          <= pc_sel_n;
      bus.squash          <= squash_n;
      bus.squash_ifid     <= squash_ifid_n;
      bus.forwarding_mask <= mask_n;
      bus.busy            <= busy_n;
    end
  end

`ifdef REDIRECT_STATS_EN
  // Saturating redirect and squash-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= 16'h0000;
      squash_cycles  <= 16'h0000;
    end else if (!stall) begin
      if (accept && (redirect_count != 16'hFFFF))
        redirect_count <= redirect_count + 16'd1;
      if (bus.squash && (squash_cycles != 16'hFFFF))
        squash_cycles <= squash_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_redirect_flush_scheduler.sv
// Directed self-checking bench for redirect_flush_scheduler.
// Observed vector layout: {pc_sel, squash, squash_ifid, forwarding_mask[1:0], busy}.
module tb_redirect_flush_scheduler;

  logic clk;
  logic rst_n;
  logic stall;
  int   total;
  int   bad;

  redirect_flush_scheduler_if bus ();

`ifdef REDIRECT_STATS_EN
  logic [15:0] redirect_count;
  logic [15:0] squash_cycles;
`endif

  redirect_flush_scheduler #(.FLUSH_DEPTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .bus   (bus)
`ifdef REDIRECT_STATS_EN
    ,
    .redirect_count (redirect_count),
    .squash_cycles  (squash_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] V_IDLE = 6'b000110;

  function automatic logic [5:0] obs();
    return {bus.pc_sel, bus.squash, bus.squash_ifid, bus.forwarding_mask, bus.busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.mem_redirect_req  = 1'b0;
    bus.mem_redirect_kind = 2'b00;
    bus.mem_redirect_pc   = 16'h0000;
    bus.id_redirect_req   = 1'b0;
    bus.id_redirect_pc    = 16'h0000;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    clear_reqs();
    stall = 1'b0;
    rst_n = 1'b0;
    #12;
    o = obs();
    total++;
    if (o !== V_IDLE || bus.pc_target !== 16'h0000) begin
      bad++;
      $display("FAIL reset_values: got %b/%h, want %b/0000", o, bus.pc_target, V_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      o = obs();
      total++;
      if (o !== V_IDLE) begin
        bad++;
        $display("FAIL reset_idle[%0d]: got %b, want %b", i, o, V_IDLE);
      end
    end
  endtask

  task automatic test_mem_flush();
    logic [5:0] exp [5] = '{6'b111111, 6'b011111, 6'b011001, 6'b000101, 6'b000110};
    logic [5:0] o;
    bus.mem_redirect_req  = 1'b1;
    bus.mem_redirect_kind = 2'b00;
    bus.mem_redirect_pc   = 16'h3000;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) clear_reqs();
      o = obs();
      total++;
      if (o !== exp[i]) begin
        bad++;
        $display("FAIL mem_flush[%0d]: got %b, want %b", i, o, exp[i]);
      end
    end
    total++;
    if (bus.pc_target !== 16'h3000) begin
      bad++;
      $display("FAIL mem_flush_target: got %h, want 3000", bus.pc_target);
    end
  endtask

  task automatic test_flush_stall();
    logic [5:0] exp [6] = '{6'b111111, 6'b011111, 6'b011111, 6'b011111,
                            6'b011001, 6'b000101};
    logic [5:0] o;
    bus.mem_redirect_req  = 1'b1;
    bus.mem_redirect_kind = 2'b01;
    bus.mem_redirect_pc   = 16'h6000;
    for (int i = 0; i < 6; i++) begin
      step();
      clear_reqs();
      stall = (i == 1 || i == 2);
      o = obs();
      total++;
      if (o !== exp[i]) begin
        bad++;
        $display("FAIL flush_stall[%0d]: got %b, want %b", i, o, exp[i]);
      end
    end
    step();
    o = obs();
    total++;
    if (o !== V_IDLE) begin
      bad++;
      $display("FAIL flush_stall_end: got %b, want %b", o, V_IDLE);
    end
  endtask

  task automatic test_stall_request();
    logic [5:0] o;
    stall = 1'b1;
    bus.mem_redirect_req = 1'b1;
    bus.mem_redirect_pc  = 16'hABCD;
    step();
    o = obs();
    total++;
    if (o !== V_IDLE || bus.pc_target !== 16'h6000) begin
      bad++;
      $display("FAIL stalled_req: got %b/%h, want %b/6000", o, bus.pc_target, V_IDLE);
    end
    stall = 1'b0;
    step();
    clear_reqs();
    o = obs();
    total++;
    if (o !== 6'b111111 || bus.pc_target !== 16'hABCD) begin
      bad++;
      $display("FAIL held_req_accept: got %b/%h, want 111111/abcd", o, bus.pc_target);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_simultaneous();
    logic [5:0] o;
    bus.mem_redirect_req  = 1'b1;
    bus.mem_redirect_kind = 2'b10;
    bus.mem_redirect_pc   = 16'h4000;
    bus.id_redirect_req   = 1'b1;
    bus.id_redirect_pc    = 16'h5000;
    step();
    o = obs();
    total++;
    if (o !== 6'b111111 || bus.pc_target !== 16'h4000) begin
      bad++;
      $display("FAIL simultaneous: got %b/%h, want 111111/4000", o, bus.pc_target);
    end
    // Younger requests during the flush must be ignored.
    bus.mem_redirect_pc = 16'h9999;
    step();
    clear_reqs();
    o = obs();
    total++;
    if (o !== 6'b011111 || bus.pc_target !== 16'h4000) begin
      bad++;
      $display("FAIL flush_ignores_req: got %b/%h, want 011111/4000", o, bus.pc_target);
    end
    for (int i = 0; i < 3; i++) step();
    o = obs();
    total++;
    if (o !== V_IDLE || bus.pc_target !== 16'h4000) begin
      bad++;
      $display("FAIL simultaneous_end: got %b/%h, want %b/4000", o, bus.pc_target, V_IDLE);
    end
  endtask

  task automatic test_id_flush();
    logic [5:0] o;
    bus.id_redirect_req = 1'b1;
    bus.id_redirect_pc  = 16'h2222;
    step();
    clear_reqs();
    o = obs();
    total++;
    if (o !== 6'b101111 || bus.pc_target !== 16'h2222) begin
      bad++;
      $display("FAIL id_flush: got %b/%h, want 101111/2222", o, bus.pc_target);
    end
    step();
    o = obs();
    total++;
    if (o !== V_IDLE) begin
      bad++;
      $display("FAIL id_flush_end: got %b, want %b", o, V_IDLE);
    end
  endtask

  task automatic test_id_preempt();
    logic [5:0] o;
    bus.id_redirect_req = 1'b1;
    bus.id_redirect_pc  = 16'h2222;
    step();
    clear_reqs();
    bus.mem_redirect_req  = 1'b1;
    bus.mem_redirect_kind = 2'b11;
    bus.mem_redirect_pc   = 16'h1111;
    step();
    clear_reqs();
    o = obs();
    total++;
    if (o !== 6'b111111 || bus.pc_target !== 16'h1111) begin
      bad++;
      $display("FAIL id_preempt: got %b/%h, want 111111/1111", o, bus.pc_target);
    end
    step();
    step();
    step();
    o = obs();
    total++;
    if (o !== 6'b000101) begin
      bad++;
      $display("FAIL preempt_post: got %b, want 000101", o);
    end
    // A new ID request is accepted straight out of S_POST.
    bus.id_redirect_req = 1'b1;
    bus.id_redirect_pc  = 16'h7777;
    step();
    clear_reqs();
    o = obs();
    total++;
    if (o !== 6'b101111 || bus.pc_target !== 16'h7777) begin
      bad++;
      $display("FAIL post_accept: got %b/%h, want 101111/7777", o, bus.pc_target);
    end
    step();
  endtask

  task automatic test_reset_mid_flush();
    logic [5:0] o;
    bus.mem_redirect_req = 1'b1;
    bus.mem_redirect_pc  = 16'h8888;
    step();
    clear_reqs();
    step();
    o = obs();
    total++;
    if (o !== 6'b011111) begin
      bad++;
      $display("FAIL pre_abort: got %b, want 011111", o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = obs();
    total++;
    if (o !== V_IDLE || bus.pc_target !== 16'h0000) begin
      bad++;
      $display("FAIL async_abort: got %b/%h, want %b/0000", o, bus.pc_target, V_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    o = obs();
    total++;
    if (o !== V_IDLE) begin
      bad++;
      $display("FAIL after_abort: got %b, want %b", o, V_IDLE);
    end
  endtask

`ifdef REDIRECT_STATS_EN
  task automatic test_stats();
    for (int r = 0; r < 2; r++) begin
      bus.mem_redirect_req = 1'b1;
      bus.mem_redirect_pc  = 16'h0100;
      step();
      clear_reqs();
      for (int i = 0; i < 4; i++) step();
    end
    total++;
    if (redirect_count !== 16'd2 || squash_cycles !== 16'd6) begin
      bad++;
      $display("FAIL stats: got %0d/%0d, want 2/6", redirect_count, squash_cycles);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mem_flush();
    test_flush_stall();
    test_stall_request();
    test_simultaneous();
    test_id_flush();
    test_id_preempt();
    test_reset_mid_flush();
`ifdef REDIRECT_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
